// File: rtl/bsg_bladerunner_rom_banked_pkg.sv
// Shared types for the banked configuration ROM responder: response-entry
// layout and the error-cause encoding used by the simulation message.
`ifndef BSG_BLADERUNNER_ROM_BANKED_PKG_SV
`define BSG_BLADERUNNER_ROM_BANKED_PKG_SV

// A response entry is {err, data}; data width follows the link width.
`define BSG_ROM_BANKED_ENTRY_WIDTH(data_width) ((data_width) + 1)
`define BSG_ROM_BANKED_ENTRY_S(data_width) \
  struct packed { logic err; logic [(data_width)-1:0] data; }

package bsg_bladerunner_rom_banked_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'd0,
    CAUSE_WRITE = 2'd1,
    CAUSE_RANGE = 2'd2
  } err_cause_e;

  // clog2 that never returns 0, so index vectors always have a legal width.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`endif

// File: rtl/bsg_bladerunner_rom_banked_if.sv
// Request/response link between the manycore endpoint (master) and the
// ROM responder (slave). Suffixes are from the responder's point of view.
interface bsg_bladerunner_rom_banked_if
  import bsg_bladerunner_rom_banked_pkg::*;
#(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 28
);
  logic                      req_v_i;
  logic [addr_width_p-1:0]   req_addr_i;
  logic                      req_we_i;
  logic [data_width_p/8-1:0] req_mask_i;
  logic                      req_yumi_o;
  logic                      resp_v_o;
  logic [data_width_p-1:0]   resp_data_o;
  logic                      resp_err_o;
  logic                      resp_ready_i;

  modport slave (
    input  req_v_i, req_addr_i, req_we_i, req_mask_i, resp_ready_i,
    output req_yumi_o, resp_v_o, resp_data_o, resp_err_o
  );

  modport master (
    output req_v_i, req_addr_i, req_we_i, req_mask_i, resp_ready_i,
    input  req_yumi_o, resp_v_o, resp_data_o, resp_err_o
  );
endinterface

// File: rtl/bsg_bladerunner_rom_resp_fifo.sv
// Synchronous circular response buffer with valid/ready drain side.
// The writer must not enqueue when o_full is set; such pushes are ignored.
module bsg_bladerunner_rom_resp_fifo
  import bsg_bladerunner_rom_banked_pkg::*;
#(
  parameter  int width_p      = 33,
  parameter  int els_p        = 4,
  localparam int ptr_width_lp = safe_clog2(els_p),
  localparam int cnt_width_lp = $clog2(els_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    i_v,
  input  logic [width_p-1:0]      i_data,
  output logic                    o_v,
  output logic [width_p-1:0]      o_data,
  input  logic                    i_ready,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [cnt_width_lp-1:0] o_count
);

  logic [width_p-1:0]      r_mem [els_p];
  logic [ptr_width_lp-1:0] r_wptr, r_rptr;
  logic [cnt_width_lp-1:0] r_count;
  logic                    w_enq, w_deq;

  assign o_full  = (r_count == cnt_width_lp'(els_p));
  assign o_empty = (r_count == '0);
  assign o_v     = ~o_empty;
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;
  assign w_enq   = i_v & ~o_full;
  assign w_deq   = o_v & i_ready;

  // Storage write port.
  // NOTE: the payload array has no reset; validity comes from r_count alone,
  // so resetting it would only add reset fan-out to every storage bit.
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr] <= i_data;
  end

  // Pointers wrap at els_p; the count moves only on an unmatched push or pop.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq)
        r_wptr <= (r_wptr == ptr_width_lp'(els_p - 1)) ? '0 : r_wptr + ptr_width_lp'(1);
      if (w_deq)
        r_rptr <= (r_rptr == ptr_width_lp'(els_p - 1)) ? '0 : r_rptr + ptr_width_lp'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + cnt_width_lp'(1);
        2'b01:   r_count <= r_count - cnt_width_lp'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bsg_bladerunner_rom_banked.sv
// Banked read-only configuration ROM responder. Decodes the word address into
// bank/word, masks the selected bank word, and queues exactly one response per
// accepted request; writes and out-of-range reads return err=1 with zero data.
// The interface instance must carry the same data/addr widths as this module.
module bsg_bladerunner_rom_banked
  import bsg_bladerunner_rom_banked_pkg::*;
#(
  parameter  int data_width_p    = 32,
  parameter  int addr_width_p    = 28,
  parameter  int rom_width_p     = 32,
  parameter  int rom_els_p       = 64,
  parameter  int num_banks_p     = 2,
  parameter  int resp_fifo_els_p = 4,
  parameter  int err_cnt_width_p = 8,
  localparam int lg_els_lp       = safe_clog2(rom_els_p),
  localparam int lg_banks_lp     = (num_banks_p > 1) ? $clog2(num_banks_p) : 0,
  localparam int bank_sel_w_lp   = safe_clog2(num_banks_p)
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  bsg_bladerunner_rom_banked_if.slave        bus_if,
  output logic [lg_els_lp-1:0]               rom_addr_o,
  input  logic [num_banks_p*rom_width_p-1:0] rom_data_i,
  input  logic                               err_clear_i,
  output logic [err_cnt_width_p-1:0]         err_cnt_o,
  output logic                               err_sticky_o
);

  typedef `BSG_ROM_BANKED_ENTRY_S(data_width_p) entry_s;
  localparam int entry_width_lp = `BSG_ROM_BANKED_ENTRY_WIDTH(data_width_p);
  localparam int cnt_width_lp   = $clog2(resp_fifo_els_p + 1);

  logic [addr_width_p-1:0]    w_upper;
  logic [bank_sel_w_lp-1:0]   w_bank;
  logic                       w_range;
  logic [rom_width_p-1:0]     w_rom_word;
  logic [data_width_p-1:0]    w_rom_ext, w_masked;
  err_cause_e                 w_cause;
  logic                       w_err, w_yumi, w_full, w_empty;
  entry_s                     w_entry, w_resp;
  logic [entry_width_lp-1:0]  w_fifo_data;
  logic [cnt_width_lp-1:0]    w_count;
  logic [err_cnt_width_p-1:0] r_err_cnt;
  logic                       r_err_sticky;

  // Everything above the word index is the bank number; any value at or past
  // num_banks_p (which includes nonzero bits above the bank field) is illegal.
  assign rom_addr_o = bus_if.req_addr_i[lg_els_lp-1:0];
  assign w_upper    = bus_if.req_addr_i >> lg_els_lp;
  assign w_bank     = w_upper[bank_sel_w_lp-1:0];
  assign w_range    = (w_upper >= addr_width_p'(num_banks_p));

  // Bank select as a compare-mux, so an illegal bank never indexes past rom_data_i.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    w_rom_word = '0;
    for (int b = 0; b < num_banks_p; b++)
      if (w_bank == bank_sel_w_lp'(b)) w_rom_word = rom_data_i[b*rom_width_p +: rom_width_p];
  end

  // Zero-extend to the link width, then gate each byte by its mask bit.
  always_comb begin
    w_rom_ext = data_width_p'(w_rom_word);
    w_masked  = '0;
    for (int i = 0; i < data_width_p/8; i++)
      w_masked[8*i +: 8] = w_rom_ext[8*i +: 8] & {8{bus_if.req_mask_i[i]}};
  end

  // Classify the request and build its response entry.
  always_comb begin
    w_cause = CAUSE_NONE;
    if (bus_if.req_we_i)  w_cause = CAUSE_WRITE;
    else if (w_range)     w_cause = CAUSE_RANGE;
    w_err        = (w_cause != CAUSE_NONE);
    w_entry.err  = w_err;
    w_entry.data = w_err ? '0 : w_masked;
  end

  // No full-bypass: a full FIFO refuses even when a dequeue happens this cycle.
  assign w_yumi            = bus_if.req_v_i & ~w_full & reset_n_i;
  assign bus_if.req_yumi_o = w_yumi;

  bsg_bladerunner_rom_resp_fifo #(
    .width_p (entry_width_lp),
    .els_p   (resp_fifo_els_p)
  ) u_resp_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .i_v       (w_yumi),
    .i_data    (w_entry),
    .o_v       (bus_if.resp_v_o),
    .o_data    (w_fifo_data),
    .i_ready   (bus_if.resp_ready_i),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  assign w_resp             = entry_s'(w_fifo_data);
  assign bus_if.resp_data_o = w_resp.data;
  assign bus_if.resp_err_o  = w_resp.err;

  // Saturating error count and sticky flag; a clear takes effect before a
  // same-cycle error is counted.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_err_cnt    <= '0;
      r_err_sticky <= 1'b0;
    end else if (w_yumi && w_err) begin
      r_err_cnt    <= err_clear_i ? err_cnt_width_p'(1)
                    : (&r_err_cnt) ? r_err_cnt : r_err_cnt + err_cnt_width_p'(1);
      r_err_sticky <= 1'b1;
    end else if (err_clear_i) begin
      r_err_cnt    <= '0;
      r_err_sticky <= 1'b0;
    end
  end

  assign err_cnt_o    = r_err_cnt;
  assign err_sticky_o = r_err_sticky;

`ifndef SYNTHESIS
  // Parameter sanity while in reset; one message per error response.
  always @(posedge clk_i) begin
    if (!reset_n_i) begin
      assert (rom_width_p <= data_width_p) else $error("rom_width_p exceeds data_width_p");
      assert (lg_els_lp + lg_banks_lp <= addr_width_p) else $error("address too narrow");
      assert (data_width_p % 8 == 0) else $error("data_width_p not a byte multiple");
    end else begin
      assert (w_empty == !bus_if.resp_v_o && w_count <= cnt_width_lp'(resp_fifo_els_p))
        else $error("response fifo state inconsistent");
      if (w_yumi && w_err)
        $display("%m: error response addr=%h cause=%s", bus_if.req_addr_i, w_cause.name());
    end
  end
`endif

endmodule

// File: tb/tb_bsg_bladerunner_rom_banked.sv
// Scoreboard bench for the banked ROM responder: a monitor pushes the model's
// expected entry on every observed accept and pops/compares on every drain.
module tb_bsg_bladerunner_rom_banked;

  typedef struct packed { logic err; logic [31:0] data; } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  rom_addr, rom_addr2;
  logic [63:0] rom_data;
  logic [31:0] rom_data2;
  logic        err_clear, err_clear2;
  logic [7:0]  err_cnt, err_cnt2;
  logic        err_sticky, err_sticky2;
  logic [31:0] rom_mem [2][64];

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;

  always #5 clk = ~clk;

  bsg_bladerunner_rom_banked_if #(.data_width_p(32), .addr_width_p(28)) bus ();
  bsg_bladerunner_rom_banked_if #(.data_width_p(32), .addr_width_p(28)) bus2 ();

  bsg_bladerunner_rom_banked dut (
    .clk_i (clk), .reset_n_i (reset_n), .bus_if (bus),
    .rom_addr_o (rom_addr), .rom_data_i (rom_data),
    .err_clear_i (err_clear), .err_cnt_o (err_cnt), .err_sticky_o (err_sticky)
  );

  bsg_bladerunner_rom_banked #(.rom_width_p(16)) dut_narrow (
    .clk_i (clk), .reset_n_i (reset_n), .bus_if (bus2),
    .rom_addr_o (rom_addr2), .rom_data_i (rom_data2),
    .err_clear_i (err_clear2), .err_cnt_o (err_cnt2), .err_sticky_o (err_sticky2)
  );

  always_comb rom_data = {rom_mem[1][rom_addr], rom_mem[0][rom_addr]};
  assign rom_data2 = {16'h1234, 16'hABCD};

  function automatic exp_t model(logic [27:0] a, logic we, logic [3:0] m);
    exp_t        e;
    logic [21:0] hi;
    logic [31:0] w;
    hi = a[27:6];
    e  = '0;
    if (we || hi > 22'd1) e.err = 1'b1;
    else begin
      w = rom_mem[hi[0]][a[5:0]];
      for (int i = 0; i < 4; i++) e.data[8*i +: 8] = m[i] ? w[8*i +: 8] : 8'h00;
    end
    return e;
  endfunction

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.req_v_i && bus.req_yumi_o)
        sb.push_back(model(bus.req_addr_i, bus.req_we_i, bus.req_mask_i));
      if (bus.resp_v_o && bus.resp_ready_i) begin
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected got data=%h err=%b want no response",
                   bus.resp_data_o, bus.resp_err_o);
        end else begin
          e = sb.pop_front();
          pops++;
          if (bus.resp_data_o !== e.data || bus.resp_err_o !== e.err) begin
            errors++;
            $display("FAIL resp_data got data=%h err=%b want data=%h err=%b",
                     bus.resp_data_o, bus.resp_err_o, e.data, e.err);
          end
        end
      end
    end
  end

  // Present one request (caller is just past a rising edge) until accepted.
  task automatic issue(input logic [27:0] a, input logic we, input logic [3:0] m);
    bit got = 0;
    bus.req_v_i = 1'b1; bus.req_addr_i = a; bus.req_we_i = we; bus.req_mask_i = m;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      got = bus.req_yumi_o;
      @(posedge clk); #1;
    end
    bus.req_v_i = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL issue_timeout got no yumi want yumi addr=%h", a);
    end
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      done = (sb.size() == 0);
    end
    @(posedge clk); #1;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.req_v_i = 1'b1; bus.req_addr_i = 28'd5; bus.req_we_i = 1'b0; bus.req_mask_i = 4'hF;
    bus.resp_ready_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (bus.req_yumi_o !== 1'b0 || bus.resp_v_o !== 1'b0 || err_cnt !== 8'd0 || err_sticky !== 1'b0) begin
        errors++;
        $display("FAIL reset_state got yumi=%b v=%b cnt=%0d sticky=%b want 0 0 0 0",
                 bus.req_yumi_o, bus.resp_v_o, err_cnt, err_sticky);
      end
    end
    @(posedge clk); #1;
    reset_n = 1'b1; bus.req_v_i = 1'b0;
  endtask

  task automatic test_latency();
    bus.req_v_i = 1'b1; bus.req_addr_i = 28'd5; bus.req_mask_i = 4'hF; bus.req_we_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_yumi_o !== 1'b1) begin
      errors++; $display("FAIL latency_yumi got %b want 1", bus.req_yumi_o);
    end
    @(posedge clk); #1;
    bus.req_v_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.resp_v_o !== 1'b1 || bus.resp_data_o !== 32'hDEADBEEF || bus.resp_err_o !== 1'b0) begin
      errors++;
      $display("FAIL latency_resp got v=%b data=%h err=%b want 1 deadbeef 0",
               bus.resp_v_o, bus.resp_data_o, bus.resp_err_o);
    end
    @(posedge clk); #1;
    wait_drain();
  endtask

  task automatic test_mask();
    issue(28'd67, 1'b0, 4'b0101);
    @(negedge clk);
    checks++;
    if (bus.resp_data_o !== 32'h00220044) begin
      errors++; $display("FAIL mask_data got %h want 00220044", bus.resp_data_o);
    end
    @(posedge clk); #1;
    issue(28'd73, 1'b0, 4'b1000);
    issue(28'd2,  1'b0, 4'b0000);
    wait_drain();
  endtask

  task automatic test_narrow();
    bus2.req_v_i = 1'b1; bus2.req_addr_i = 28'd0; bus2.req_mask_i = 4'hF;
    @(negedge clk);
    checks++;
    if (bus2.req_yumi_o !== 1'b1) begin
      errors++; $display("FAIL narrow_yumi got %b want 1", bus2.req_yumi_o);
    end
    @(posedge clk); #1;
    bus2.req_addr_i = 28'd64; bus2.req_mask_i = 4'b0010;
    @(negedge clk);
    checks++;
    if (bus2.resp_v_o !== 1'b1 || bus2.resp_data_o !== 32'h0000ABCD || bus2.resp_err_o !== 1'b0) begin
      errors++;
      $display("FAIL narrow_ext got v=%b data=%h err=%b want 1 0000abcd 0",
               bus2.resp_v_o, bus2.resp_data_o, bus2.resp_err_o);
    end
    @(posedge clk); #1;
    bus2.req_v_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus2.resp_v_o !== 1'b1 || bus2.resp_data_o !== 32'h00001200) begin
      errors++;
      $display("FAIL narrow_mask got v=%b data=%h want 1 00001200", bus2.resp_v_o, bus2.resp_data_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [27:0] addrs [6];
    int idx = 0;
    int pops0 = pops;
    addrs = '{28'd5, 28'd67, 28'd3, 28'd74, 28'd20, 28'd127};
    bus.resp_ready_i = 1'b0;
    bus.req_v_i = 1'b1; bus.req_addr_i = addrs[0]; bus.req_we_i = 1'b0; bus.req_mask_i = 4'hF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.req_yumi_o) idx++;
      if (c >= 6) begin
        checks++;
        if (bus.resp_v_o !== 1'b1 || sb.size() == 0 || bus.resp_data_o !== sb[0].data) begin
          errors++;
          $display("FAIL stall_hold got v=%b data=%h want held head", bus.resp_v_o, bus.resp_data_o);
        end
      end
      @(posedge clk); #1;
      if (idx < 6) bus.req_addr_i = addrs[idx];
    end
    checks++;
    if (idx != 4) begin
      errors++; $display("FAIL stall_accepts got %0d want 4", idx);
    end
    bus.resp_ready_i = 1'b1;
    for (int c = 0; c < 20 && idx < 6; c++) begin
      @(negedge clk);
      if (bus.req_yumi_o) idx++;
      @(posedge clk); #1;
      if (idx < 6) bus.req_addr_i = addrs[idx];
    end
    bus.req_v_i = 1'b0;
    checks++;
    if (idx != 6) begin
      errors++; $display("FAIL resume_accepts got %0d want 6", idx);
    end
    wait_drain();
    checks++;
    if (pops - pops0 != 6) begin
      errors++; $display("FAIL resp_count got %0d want 6", pops - pops0);
    end
  endtask

  task automatic test_errors();
    err_clear = 1'b1; @(posedge clk); #1; err_clear = 1'b0;
    issue(28'd5,   1'b1, 4'hF);
    issue(28'd129, 1'b0, 4'hF);
    issue(28'd6,   1'b0, 4'hF);
    checks++;
    if (err_cnt !== 8'd2 || err_sticky !== 1'b1) begin
      errors++; $display("FAIL err_count got cnt=%0d sticky=%b want 2 1", err_cnt, err_sticky);
    end
    issue(28'h1000005, 1'b0, 4'hF);
    checks++;
    if (err_cnt !== 8'd3) begin
      errors++; $display("FAIL err_upper_bits got cnt=%0d want 3", err_cnt);
    end
    wait_drain();
  endtask

  task automatic test_saturate();
    err_clear = 1'b1; @(posedge clk); #1; err_clear = 1'b0;
    for (int i = 0; i < 300; i++) issue(28'(i % 64), 1'b1, 4'hF);
    checks++;
    if (err_cnt !== 8'd255 || err_sticky !== 1'b1) begin
      errors++; $display("FAIL err_saturate got cnt=%0d sticky=%b want 255 1", err_cnt, err_sticky);
    end
    err_clear = 1'b1;
    issue(28'd9, 1'b1, 4'hF);
    err_clear = 1'b0;
    checks++;
    if (err_cnt !== 8'd1 || err_sticky !== 1'b1) begin
      errors++; $display("FAIL clear_with_err got cnt=%0d sticky=%b want 1 1", err_cnt, err_sticky);
    end
    err_clear = 1'b1; @(posedge clk); #1; err_clear = 1'b0;
    checks++;
    if (err_cnt !== 8'd0 || err_sticky !== 1'b0) begin
      errors++; $display("FAIL clear_alone got cnt=%0d sticky=%b want 0 0", err_cnt, err_sticky);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    bus.resp_ready_i = 1'b0;
    issue(28'd5,  1'b0, 4'hF);
    issue(28'd67, 1'b0, 4'hF);
    issue(28'd7,  1'b1, 4'hF);
    @(negedge clk);
    checks++;
    if (bus.resp_v_o !== 1'b1 || err_cnt !== 8'd1) begin
      errors++; $display("FAIL pre_reset got v=%b cnt=%0d want 1 1", bus.resp_v_o, err_cnt);
    end
    @(posedge clk); #1;
    reset_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.resp_v_o !== 1'b0 || err_cnt !== 8'd0 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got v=%b cnt=%0d sticky=%b want 0 0 0", bus.resp_v_o, err_cnt, err_sticky);
    end
    @(posedge clk); #1;
    bus.resp_ready_i = 1'b1;
    test_latency();
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int w = 0; w < 64; w++)
        rom_mem[b][w] = 32'h5A000000 + (32'(b) << 20) + 32'(w) * 32'h00010307;
    rom_mem[0][5] = 32'hDEADBEEF;
    rom_mem[1][3] = 32'h11223344;
    err_clear = 1'b0; err_clear2 = 1'b0;
    bus2.req_v_i = 1'b0; bus2.req_addr_i = '0; bus2.req_we_i = 1'b0;
    bus2.req_mask_i = 4'hF; bus2.resp_ready_i = 1'b1;

    test_reset();
    test_latency();
    test_mask();
    test_narrow();
    test_back_to_back();
    test_errors();
    test_saturate();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bsg_bladerunner_rom_banked.md
Name: bsg_bladerunner_rom_banked

Overview:
Multi-bank, read-only configuration ROM responder for the manycore host-visible configuration space. It generalises the single-ROM responder: N ROM banks, arbitrary ROM/link widths, buffered responses with backpressure, and error responses instead of simulation aborts. It sits behind a manycore endpoint; the endpoint presents requests here and drains responses back to the network.

Parameters:
data_width_p, 32, link data width; a multiple of 8.
addr_width_p, 28, link word-address width.
rom_width_p, 32, ROM word width; must be <= data_width_p; zero-extended.
rom_els_p, 64, words per bank.
num_banks_p, 2, number of ROM banks; >= 1.
resp_fifo_els_p, 4, response FIFO depth; >= 2.
err_cnt_width_p, 8, width of the saturating error counter.

Ports:
clk_i  in  1  clock
reset_n_i  in  1  synchronous, active-low reset
req_v_i  in  1  request valid
req_addr_i  in  addr_width_p  word address: bank = addr[lg_els+:lg_banks], word = addr[lg_els-1:0]
req_we_i  in  1  write request (illegal)
req_mask_i  in  data_width_p/8  byte mask for the read
req_yumi_o  out  1  request consumed this cycle
resp_v_o  out  1  response valid
resp_data_o  out  data_width_p  masked, zero-extended ROM word
resp_err_o  out  1  response marks a write or an out-of-range access
resp_ready_i  in  1  consumer accepts the response
rom_addr_o  out  lg_els  word index broadcast to all banks (combinational from req_addr_i)
rom_data_i  in  num_banks_p*rom_width_p  combinational bank read data; bank b at [b*rom_width_p+:rom_width_p]
err_clear_i  in  1  clear err_cnt_o and err_sticky_o
err_cnt_o  out  err_cnt_width_p  saturating count of error responses
err_sticky_o  out  1  set on the first error; held until err_clear_i

Behaviour:
- lg_els = BSG_SAFE_CLOG2(rom_els_p); lg_banks = BSG_SAFE_CLOG2(num_banks_p), treated as 0 width when num_banks_p = 1.
- Reset (reset_n_i = 0 at a clock edge): FIFO emptied, pointers and count = 0, resp_v_o = 0, req_yumi_o = 0, err_cnt_o = 0, err_sticky_o = 0. Reset mid-operation drops all queued responses. No request is accepted while reset is asserted.
- Accept: req_yumi_o = req_v_i & ~fifo_full & reset_n_i. A full FIFO with a same-cycle dequeue does not accept. The design choice is no full-bypass.
- On accept at cycle N, one response entry is enqueued at edge N. resp_v_o is high from cycle N+1, so read latency is 1 cycle when the FIFO is empty. Responses leave in request order.
- Out-of-range: the bank index is >= num_banks_p, or any address bit at or above lg_els+lg_banks is nonzero.
- Entry contents:
  - Legal read: data = zero-extended rom_data_i[bank], each byte i ANDed with req_mask_i[i]; err = 0.
  - Write or out-of-range access: data = 0, err = 1.
- Every request, including an illegal one, gets exactly one response so that requester credits always return.
- Dequeue when resp_v_o & resp_ready_i. Simultaneous enqueue and dequeue leaves the count unchanged and is legal at any occupancy except full-accept.
- Pointers wrap modulo resp_fifo_els_p. Count spans 0..resp_fifo_els_p. full = (count == resp_fifo_els_p); empty = (count == 0).
- resp_data_o and resp_err_o hold stable while resp_v_o = 1 and resp_ready_i = 0. The consumer may drop resp_ready_i at any time.
- Error counter: on an accepted error request, err_cnt_o increments and saturates at all-ones, and err_sticky_o is set.
  - err_clear_i alone: both clear to 0.
  - err_clear_i together with an accepted error: err_cnt_o = 1 and err_sticky_o = 1, because the clear applies first.
- Simulation-only checks: rom_width_p <= data_width_p; lg_els+lg_banks <= addr_width_p; data_width_p % 8 == 0. An error response prints one $display line with the address and the cause, and does not $finish.

Decomposition:
- Package bsg_bladerunner_rom_banked_pkg holds:
  - the parametrised response-entry layout {err, data}, defined through a width macro;
  - the error-cause encoding (none/write/range) used by the simulation message.
- Sub-module bsg_bladerunner_rom_resp_fifo: a synchronous circular buffer with valid/ready output, count, full and empty. The top level holds address decode, masking, accept logic and the error counter.

Test Plan:
- Read bank 0 word 5 with mask 4'hF and rom word 32'hDEADBEEF, resp_ready_i = 1 -> req_yumi_o in cycle N, resp_v_o in N+1 with data 32'hDEADBEEF and err 0.
- Read bank 1 word 3 with mask 4'b0101 and rom word 32'h11223344 -> data 32'h00220044. With rom_width_p = 16 and data_width_p = 32, rom word 16'hABCD -> 32'h0000ABCD.
- Hold resp_ready_i = 0 and issue 6 reads (depth 4) -> exactly 4 yumis, then req_yumi_o = 0. Then release resp_ready_i -> 4 in-order responses, and stalled requests resume with no loss or duplication.
- Issue a write, then an address with bank index 2 (num_banks_p = 2), then a read -> responses with err 1 data 0, err 1 data 0, then valid data. err_cnt_o = 2 and err_sticky_o = 1.
- Issue 300 writes with err_cnt_width_p = 8 -> err_cnt_o saturates at 255. err_clear_i together with an error -> err_cnt_o = 1.
- Fill the FIFO with 3 entries and assert reset_n_i = 0 for 1 cycle -> resp_v_o = 0 and err_cnt_o = 0 the next cycle. A fresh read returns with latency 1.
